// File: rtl/led_display_pattern_gen_bcm_pkg.sv
// Shared constants and row layout for the BCM pattern generator.
// Mode encodings, default geometry/depth and the packed row struct (top_red in the MSBs).
package led_display_pattern_gen_bcm_pkg;

    localparam logic [3:0] MODE_OFF     = 4'd0;
    localparam logic [3:0] MODE_SOLID   = 4'd1;
    localparam logic [3:0] MODE_SCAN_V  = 4'd2;
    localparam logic [3:0] MODE_SCAN_H  = 4'd3;
    localparam logic [3:0] MODE_PULSE   = 4'd4;
    localparam logic [3:0] MODE_CHECKER = 4'd5;

    localparam int GL_NUM_COL_PIXELS = 64;
    localparam int GL_COLOUR_DEPTH   = 4;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] top_red;
        logic [GL_NUM_COL_PIXELS-1:0] top_green;
        logic [GL_NUM_COL_PIXELS-1:0] top_blue;
        logic [GL_NUM_COL_PIXELS-1:0] bot_red;
        logic [GL_NUM_COL_PIXELS-1:0] bot_green;
        logic [GL_NUM_COL_PIXELS-1:0] bot_blue;
    } rgb_row_t;

endpackage

// File: rtl/led_display_frame_ticker.sv
// Free-running animation tick divider: one-cycle tick every SYS_CLK_FREQ/FRAME_RATE cycles
// (100 cycles when SIMULATION is set); no backpressure, it never stalls.
module led_display_frame_ticker #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int FRAME_RATE   = 60,
    parameter int SIMULATION   = 0
) (
    input  logic clk_in,
    input  logic n_reset_in,
    output logic tick
);

    localparam int TICK_CYCLES = (SIMULATION != 0) ? 100 : SYS_CLK_FREQ / FRAME_RATE;
    localparam int CNT_W       = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/led_display_pattern_gen_bcm.sv
// BCM test-pattern source: streams (plane, row-pair) beats, one per cycle, registered outputs.
// valid stays high after reset; outputs hold while !ready; mode/colour latched per frame.
module led_display_pattern_gen_bcm
    import led_display_pattern_gen_bcm_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = GL_NUM_COL_PIXELS,
    parameter int COLOUR_DEPTH   = GL_COLOUR_DEPTH,
    parameter int FRAME_RATE     = 60,
    parameter int SIMULATION     = 0
) (
    input  logic                                   clk_in,
    input  logic                                   n_reset_in,
    input  logic [3:0]                             mode_in,
    input  logic [3*COLOUR_DEPTH-1:0]              colour_in,
    output logic [6*NUM_COL_PIXELS-1:0]            row_out,
    output logic                                   row_valid_out,
    input  logic                                   row_ready_in,
    output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]    row_address_out,
    output logic [(COLOUR_DEPTH > 1 ? $clog2(COLOUR_DEPTH) : 1)-1:0] plane_out,
    output logic                                   frame_start_out
);

    localparam int R       = NUM_ROW_PIXELS;
    localparam int C       = NUM_COL_PIXELS;
    localparam int D       = COLOUR_DEPTH;
    localparam int HALF    = R / 2;
    localparam int ADDR_W  = $clog2(HALF);
    localparam int PLANE_W = (D > 1) ? $clog2(D) : 1;
    localparam int COL_W   = $clog2(C);
    localparam int ROW_W   = $clog2(R);

    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(HALF - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(D - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(C - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(R - 1);
    localparam logic [D-1:0]       LEVEL_MAX  = '1;

    logic tick;

    led_display_frame_ticker #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .FRAME_RATE   (FRAME_RATE),
        .SIMULATION   (SIMULATION)
    ) u_ticker (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .tick       (tick)
    );

    // Frame-level state: latched inputs plus animation, held for the whole frame
    logic             tick_pend;
    logic [3:0]       frame_mode,   mode_nxt;
    logic [3*D-1:0]   frame_colour, colour_nxt;
    logic [COL_W-1:0] scan_col,     scan_col_nxt;
    logic [ROW_W-1:0] scan_row,     scan_row_nxt;
    logic [D-1:0]     level,        level_nxt;
    logic             level_down,   level_down_nxt;
    logic             checker_inv,  checker_inv_nxt;

    logic                load, frame_load;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [PLANE_W-1:0]  plane_nxt;
    logic [6*C-1:0]      row_nxt;
    logic [ROW_W-1:0]    prow;
    logic                lit;
    logic [D-1:0]        cap, chan, pix;

    always_comb begin
        addr_nxt  = '0;
        plane_nxt = '0;
        if (row_valid_out) begin
            if (row_address_out == ADDR_LAST) begin
                plane_nxt = (plane_out == PLANE_LAST) ? '0 : plane_out + 1'b1;
            end else begin
                addr_nxt  = row_address_out + 1'b1;
                plane_nxt = plane_out;
            end
        end
    end

    assign load       = !row_valid_out || row_ready_in;
    assign frame_load = load && (addr_nxt == '0) && (plane_nxt == '0);

    // A mode change restarts the animation; otherwise one pending tick advances it
    always_comb begin
        mode_nxt        = frame_mode;
        colour_nxt      = frame_colour;
        scan_col_nxt    = scan_col;
        scan_row_nxt    = scan_row;
        level_nxt       = level;
        level_down_nxt  = level_down;
        checker_inv_nxt = checker_inv;
        if (frame_load) begin
            mode_nxt   = mode_in;
            colour_nxt = colour_in;
            if (mode_in != frame_mode) begin
                scan_col_nxt    = '0;
                scan_row_nxt    = '0;
                level_nxt       = '0;
                level_down_nxt  = 1'b0;
                checker_inv_nxt = 1'b0;
            end else if (tick_pend || tick) begin
                scan_col_nxt    = (scan_col == COL_LAST) ? '0 : scan_col + 1'b1;
                scan_row_nxt    = (scan_row == ROW_LAST) ? '0 : scan_row + 1'b1;
                checker_inv_nxt = !checker_inv;
                if (!level_down) begin
                    if (level == LEVEL_MAX) begin
                        level_nxt      = level - 1'b1;
                        level_down_nxt = 1'b1;
                    end else begin
                        level_nxt = level + 1'b1;
                    end
                end else if (level == '0) begin
                    level_nxt      = {{(D-1){1'b0}}, 1'b1};
                    level_down_nxt = 1'b0;
                end else begin
                    level_nxt = level - 1'b1;
                end
            end
        end
    end

    // Row fields ordered top r/g/b then bottom r/g/b, top_red in the MSBs
    always_comb begin
        row_nxt = '0;
        prow    = '0;
        lit     = 1'b0;
        cap     = LEVEL_MAX;
        chan    = '0;
        pix     = '0;
        for (int half = 0; half < 2; half++) begin
            for (int c = 0; c < C; c++) begin
                prow = ROW_W'(addr_nxt) + ROW_W'(half * HALF);
                cap  = LEVEL_MAX;
                case (mode_nxt)
                    MODE_SOLID:   lit = 1'b1;
                    MODE_SCAN_V:  lit = (COL_W'(c) == scan_col_nxt);
                    MODE_SCAN_H:  lit = (prow == scan_row_nxt);
                    MODE_PULSE: begin
                        lit = 1'b1;
                        cap = level_nxt;
                    end
                    MODE_CHECKER: lit = ((((c / 8) + (int'(prow) / 8)) % 2) == 0) ^ checker_inv_nxt;
                    default:      lit = 1'b0;
                endcase
                for (int ch = 0; ch < 3; ch++) begin
                    chan = colour_nxt[ch*D +: D];
                    pix  = lit ? ((chan < cap) ? chan : cap) : '0;
                    row_nxt[(5 - (half * 3 + ch)) * C + c] = pix[plane_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            tick_pend       <= 1'b0;
            frame_mode      <= '0;
            frame_colour    <= '0;
            scan_col        <= '0;
            scan_row        <= '0;
            level           <= '0;
            level_down      <= 1'b0;
            checker_inv     <= 1'b0;
            row_valid_out   <= 1'b0;
            row_out         <= '0;
            row_address_out <= '0;
            plane_out       <= '0;
            frame_start_out <= 1'b0;
        end else begin
            tick_pend    <= frame_load ? 1'b0 : (tick_pend | tick);
            frame_mode   <= mode_nxt;
            frame_colour <= colour_nxt;
            scan_col     <= scan_col_nxt;
            scan_row     <= scan_row_nxt;
            level        <= level_nxt;
            level_down   <= level_down_nxt;
            checker_inv  <= checker_inv_nxt;
            if (load) begin
                row_valid_out   <= 1'b1;
                row_out         <= row_nxt;
                row_address_out <= addr_nxt;
                plane_out       <= plane_nxt;
                frame_start_out <= frame_load;
            end
        end
    end

endmodule

// File: tb/tb_led_display_pattern_gen_bcm.sv
// Self-checking bench: per-cycle reference model plus directed literal checks.
module tb_led_display_pattern_gen_bcm;
    import led_display_pattern_gen_bcm_pkg::*;

    localparam int R = 32, C = 64, D = 4, HALF = R / 2, FRAME_BEATS = D * HALF;
    localparam int RW = 6 * C, TICK = 100, LMAX = (1 << D) - 1;
    localparam logic [C-1:0] ONES = '1, ZEROS = '0;
    localparam logic [RW-1:0] SOLID_P0 = {ZEROS, ZEROS, ONES, ZEROS, ZEROS, ONES};
    localparam logic [RW-1:0] SOLID_P1 = {ONES, ZEROS, ONES, ONES, ZEROS, ONES};

    logic           clk_in = 1'b0;
    logic           n_reset_in = 1'b0;
    logic [3:0]     mode_in = MODE_OFF;
    logic [3*D-1:0] colour_in = '0;
    logic           row_ready_in = 1'b0;
    logic [RW-1:0]  row_out;
    logic           row_valid_out;
    logic [3:0]     row_address_out;
    logic [1:0]     plane_out;
    logic           frame_start_out;

    int n_cmp = 0;
    int n_err = 0;

    led_display_pattern_gen_bcm #(
        .SYS_CLK_FREQ(100_000_000), .NUM_ROW_PIXELS(R), .NUM_COL_PIXELS(C),
        .COLOUR_DEPTH(D), .FRAME_RATE(60), .SIMULATION(1)
    ) dut (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .mode_in(mode_in), .colour_in(colour_in),
        .row_out(row_out), .row_valid_out(row_valid_out), .row_ready_in(row_ready_in),
        .row_address_out(row_address_out), .plane_out(plane_out), .frame_start_out(frame_start_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected row from the pattern rules; k counts animation steps since the mode began
    function automatic logic [RW-1:0] model_row(input logic [3:0] mode, input logic [3*D-1:0] col,
                                                input int k, input int plane, input int addr);
        logic [RW-1:0] r;
        int lvl, prow, chan, inten;
        r   = '0;
        lvl = k % (2 * LMAX);
        if (lvl > LMAX) lvl = 2 * LMAX - lvl;
        for (int half = 0; half < 2; half++) begin
            for (int c = 0; c < C; c++) begin
                prow = addr + half * HALF;
                for (int ch = 0; ch < 3; ch++) begin
                    chan = int'(col[ch*D +: D]);
                    case (mode)
                        MODE_SOLID:   inten = chan;
                        MODE_SCAN_V:  inten = (c == k % C) ? chan : 0;
                        MODE_SCAN_H:  inten = (prow == k % R) ? chan : 0;
                        MODE_PULSE:   inten = (chan < lvl) ? chan : lvl;
                        MODE_CHECKER: inten = (((c / 8 + prow / 8) + k) % 2 == 0) ? chan : 0;
                        default:      inten = 0;
                    endcase
                    r[(5 - (half * 3 + ch)) * C + c] = inten[plane];
                end
            end
        end
        return r;
    endfunction

    bit             m_valid = 0;
    bit             m_tick = 0;
    int             m_f = 0, m_k = 0, m_edge = 0;
    logic [3:0]     m_mode = MODE_OFF;
    logic [3*D-1:0] m_col = '0;

    always @(negedge clk_in) begin
        if (!n_reset_in) begin
            check("rst_valid", RW'(row_valid_out), RW'(0));
            check("rst_row", row_out, '0);
            check("rst_addr", RW'(row_address_out), RW'(0));
            check("rst_plane", RW'(plane_out), RW'(0));
            check("rst_fstart", RW'(frame_start_out), RW'(0));
            m_valid = 0; m_tick = 0; m_f = 0; m_k = 0; m_edge = 0;
            m_mode = MODE_OFF; m_col = '0;
        end else begin
            if (m_valid) begin
                check("valid", RW'(row_valid_out), RW'(1));
                check("plane", RW'(plane_out), RW'(m_f / HALF));
                check("addr", RW'(row_address_out), RW'(m_f % HALF));
                check("fstart", RW'(frame_start_out), RW'(m_f == 0));
                check("row", row_out, model_row(m_mode, m_col, m_k, m_f / HALF, m_f % HALF));
            end else begin
                check("valid_pre", RW'(row_valid_out), RW'(0));
            end
            m_edge++;
            if (m_edge % TICK == 0) m_tick = 1;
            if (!m_valid || row_ready_in) begin
                m_f = m_valid ? (m_f + 1) % FRAME_BEATS : 0;
                m_valid = 1;
                if (m_f == 0) begin
                    if (mode_in != m_mode) m_k = 0;
                    else if (m_tick) m_k++;
                    m_tick = 0;
                    m_mode = mode_in;
                    m_col  = colour_in;
                end
            end
        end
    end

    task automatic wait_beat(input int p, input int a, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (row_valid_out && plane_out == p && row_address_out == a) found = 1;
            else begin @(posedge clk_in); #1; end
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL %s: beat (%0d,%0d) not seen within budget", name, p, a);
        end
    endtask

    initial begin
        rgb_row_t   rr;
        int         last, steps, wraps, col, nseq, last_l;
        bit         started;
        logic [D-1:0] lv;
        int         seq[64];
        int         exp_l[32] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,
                                 14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,1};

        // Reset, release with ready low, hold
        repeat (3) @(posedge clk_in);
        #1 n_reset_in = 1'b1;
        @(posedge clk_in); #1;
        check("first_valid", RW'(row_valid_out), RW'(1));
        check("first_fstart", RW'(frame_start_out), RW'(1));
        check("first_addr", RW'(row_address_out), RW'(0));
        check("first_plane", RW'(plane_out), RW'(0));
        repeat (50) @(posedge clk_in);
        #1;

        // OFF -> SOLID mid-frame at (2,7)
        row_ready_in = 1'b1;
        wait_beat(2, 7, "wait_2_7");
        mode_in   = MODE_SOLID;
        colour_in = 12'hF0A;
        wait_beat(3, 15, "wait_3_15");
        check("off_tail_row", row_out, '0);
        wait_beat(0, 0, "wait_solid_start");
        check("solid_fstart", RW'(frame_start_out), RW'(1));
        check("solid_p0_row", row_out, SOLID_P0);
        wait_beat(1, 5, "wait_1_5");
        check("solid_p1_row", row_out, SOLID_P1);

        // Random ready
        repeat (2000) begin
            @(posedge clk_in); #1;
            row_ready_in = 1'($urandom_range(0, 1));
        end
        row_ready_in = 1'b1;

        // SCAN_V sweep and wrap
        mode_in = MODE_SCAN_V; colour_in = '1;
        last = -1; steps = 0; wraps = 0;
        repeat (6800) begin
            @(posedge clk_in); #1;
            if (row_valid_out && frame_start_out) begin
                rr  = row_out;
                col = -1;
                for (int c = 0; c < C; c++) if (rr.top_red[c]) col = c;
                check("scanv_onehot", RW'($countones(rr.top_red)), RW'(1));
                if (last < 0) check("scanv_start", RW'(col), RW'(0));
                else if (col != last) begin
                    check("scanv_step", RW'(col), RW'((last + 1) % C));
                    steps++;
                    if (col == 0) wraps++;
                end
                last = col;
            end
        end
        check("scanv_steps_ge64", RW'(steps >= 64), RW'(1));
        check("scanv_wrapped", RW'(wraps >= 1), RW'(1));

        // PULSE triangle
        mode_in = MODE_PULSE;
        nseq = 0; last_l = -1; started = 0; lv = '0;
        repeat (3600) begin
            @(posedge clk_in); #1;
            if (frame_start_out) started = 1;
            if (started && row_address_out == 0) begin
                rr = row_out;
                lv[plane_out] = rr.top_red[0];
                if (plane_out == D - 1 && int'(lv) != last_l && nseq < 64) begin
                    seq[nseq] = int'(lv);
                    nseq++;
                    last_l = int'(lv);
                end
            end
        end
        check("pulse_len", RW'(nseq >= 32), RW'(1));
        for (int i = 0; i < 32; i++)
            check($sformatf("pulse_seq_%0d", i), RW'(seq[i]), RW'(exp_l[i]));

        // Reset mid-frame, then level restarts at 0
        wait_beat(1, 9, "wait_1_9");
        n_reset_in = 1'b0;
        #1;
        check("midrst_row", row_out, '0);
        check("midrst_valid", RW'(row_valid_out), RW'(0));
        check("midrst_addr", RW'(row_address_out), RW'(0));
        check("midrst_plane", RW'(plane_out), RW'(0));
        repeat (3) @(posedge clk_in);
        #1 n_reset_in = 1'b1;
        @(posedge clk_in); #1;
        check("rel_fstart", RW'(frame_start_out), RW'(1));
        lv = '1;
        repeat (FRAME_BEATS) begin
            if (row_address_out == 0) begin
                rr = row_out;
                lv[plane_out] = rr.top_red[0];
            end
            @(posedge clk_in); #1;
        end
        check("pulse_after_reset", RW'(lv), RW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
